dacxx1s101: RTL and testbench
=============================

Name: dacxx1s101

Overview:
- Write-side controller for the TI DACxx1S101 family of serial DACs (8/10/12-bit, SYNC/SCLK/DIN); the transmit counterpart to the ADCXX1S101 capture controller.
- Takes a parallel sample plus power-down mode and serializes one 16-bit frame per request.
- Uses the same active-low start / active-low complete acknowledge handshake as the ADC side, so fabric logic drives both identically.
- Sits between the sample-generation logic and the DAC pins.

Parameters:
- DAC_RES, 12, DAC resolution in bits; legal values 8, 10, 12.
- SCLK_DIV, 1, SCLK half-period in clk cycles (SCLK = clk/(2*SCLK_DIV)); legal range 1..15.
- SYNC_HIGH_CYCLES, 2, minimum clk cycles SYNC stays high between frames; legal range 1..15.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- startWrite  in  1  active low; request a frame write
- datain  in  DAC_RES  sample, MSB first on the wire; sampled when a frame starts
- pdMode  in  2  power-down bits PD1:PD0 (00 normal, 01 1k to GND, 10 100k to GND, 11 hi-Z); sampled with datain
- sync  out  1  DAC SYNC, active low frame enable
- sclk  out  1  DAC serial clock; idles high
- mosi  out  1  DAC DIN; changes only on sclk rising edges or at frame start
- writeComplete  out  1  active low; frame done, held until startWrite returns high
- busy  out  1  high from frame start through the end of quiet time

Behaviour:
- Reset values: sync=1, sclk=1, mosi=0, writeComplete=1, busy=1. Quiet counter is loaded with SYNC_HIGH_CYCLES and the armed flag is set.
- Reset asserted mid-frame: sync rises on that edge and the frame is aborted (the DAC ignores frames with fewer than 16 falling edges). The next frame is allowed only after the quiet time.
- Frame word, 16 bits MSB first:
  - bits 15:14 = 00
  - bits 13:12 = pdMode
  - next DAC_RES bits = datain
  - remaining low bits = 0
- States: IDLE, SHIFT, QUIET.
- IDLE → SHIFT: in the cycle where startWrite==0, armed==1 and the quiet counter is 0:
  - latch the frame into the shift register;
  - on the next edge: sync=0, sclk=1, mosi=bit15, busy=1, armed=0.
- SHIFT:
  - sclk toggles every SCLK_DIV cycles; the DAC samples mosi on sclk falling edges.
  - On each sclk rising edge, the shift register moves left and mosi presents the next bit.
  - After the 16th low phase ends, on the same edge: sclk=1, sync=1, writeComplete=0, quiet counter=SYNC_HIGH_CYCLES, state → QUIET.
  - sync is low for exactly 32*SCLK_DIV cycles (32 with defaults).
- QUIET: quiet counter decrements to 0, then state → IDLE and busy=0.
- Ack / re-arm:
  - While writeComplete==0 and startWrite==1: writeComplete=1 on the next edge and armed=1.
  - This applies in any state.
  - Holding startWrite low never starts a second frame.
- startWrite, datain and pdMode changes during SHIFT or QUIET are ignored.
- Start-to-complete latency: 1 + 32*SCLK_DIV cycles.
- Minimum frame period: 32*SCLK_DIV + SYNC_HIGH_CYCLES + 2 cycles with an immediate ack.

Optional Feature:
- Macro: DACXX1S101_SKIP_REDUNDANT_EN.
- Defined:
  - The block keeps the last transmitted {pdMode, datain}.
  - On an IDLE start whose word equals the last one (after at least one frame has been sent since reset), no frame is sent: sync stays high, writeComplete=0 on the next edge, and the normal ack rule applies.
  - Reset clears the valid flag for the stored word.
- Undefined: every start sends a frame.

Decomposition:
- Package dacxx1s101_pkg holds:
  - FRAME_BITS=16;
  - PD mode constants PD_NORMAL/PD_1K/PD_100K/PD_HIZ;
  - state encoding IDLE/SHIFT/QUIET;
  - a frame-packing function (pdMode, datain, DAC_RES) → 16 bits.
- Sub-module dacxx1s101_sclk_gen holds:
  - the SCLK_DIV divider;
  - sclk;
  - rise/fall strobes;
  - the 16-period counter and a last-period flag.
- The top level holds the FSM, shift register, handshake and quiet counter.

Test Plan:
- Defaults; datain=0xABC, pdMode=00, startWrite pulsed low → sync low 32 cycles; 16 bits captured at sclk falls = 0x0ABC; writeComplete low on the cycle sync rises; startWrite high → writeComplete=1 next cycle.
- pdMode=11, datain=0x000, DAC_RES=8, datain=0xFF → captured words 0x3000 and 0x0FF0 respectively.
- SCLK_DIV=3 → sclk high/low 3 cycles each; sync low 96 cycles; mosi stable for ≥3 cycles around each falling edge.
- startWrite held low across two frame periods → exactly one frame; release then re-assert → second frame starts no earlier than SYNC_HIGH_CYCLES after sync rose.
- reset asserted at the 7th sclk fall → same edge: sync=1, sclk=1, writeComplete=1; a start immediately after reset is delayed until the quiet time expires.
- With DACXX1S101_SKIP_REDUNDANT_EN: write 0x123 twice → second request completes in 1 cycle with no sync activity; write 0x124 → frame sent.

Source files
------------

// File: rtl/dacxx1s101_pkg.sv
// dacxx1s101_pkg: shared constants, state encoding and frame packing for the
// DACxx1S101 serial write controller.
package dacxx1s101_pkg;

    localparam int FRAME_BITS = 16;

    // Power-down field values (PD1:PD0) carried in frame bits 13:12.
    localparam logic [1:0] PD_NORMAL = 2'b00;
    localparam logic [1:0] PD_1K     = 2'b01;
    localparam logic [1:0] PD_100K   = 2'b10;
    localparam logic [1:0] PD_HIZ    = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        QUIET = 2'd2
    } state_e;

    // Build the 16-bit wire word: 00, PD1:PD0, sample left-justified in the
    // 12-bit data field, unused low bits zero. data is the sample
    // zero-extended to 12 bits; res is the DAC resolution (8, 10 or 12).
    function automatic logic [FRAME_BITS-1:0] pack_frame(input logic [1:0]  pd,
                                                         input logic [11:0] data,
                                                         input int          res);
        logic [FRAME_BITS-1:0] word;
        word = {2'b00, pd, 12'h000};
        word = word | ({4'h0, data} << (12 - res));
        return word;
    endfunction

endpackage

// File: rtl/dacxx1s101_if.sv
// dacxx1s101_if: fabric-side handshake plus DAC pin bundle. The master is the
// sample-generation logic; the slave is the serial write controller.
interface dacxx1s101_if #(
    parameter int DAC_RES = 12
);
    logic               startWrite;
    logic [DAC_RES-1:0] datain;
    logic [1:0]         pdMode;
    logic               sync;
    logic               sclk;
    logic               mosi;
    logic               writeComplete;
    logic               busy;

    modport master (
        output startWrite, datain, pdMode,
        input  sync, sclk, mosi, writeComplete, busy
    );

    modport slave (
        input  startWrite, datain, pdMode,
        output sync, sclk, mosi, writeComplete, busy
    );
endinterface

// File: rtl/dacxx1s101_sclk_gen.sv
// dacxx1s101_sclk_gen: SCLK divider for one frame. While run_i is high, sclk
// toggles every SCLK_DIV clk cycles starting from the high level; rise_o is a
// one-cycle strobe in the cycle before sclk rises, last_o marks the 16th low
// phase. While run_i is low sclk idles high and all counters clear.
module dacxx1s101_sclk_gen #(
    parameter int SCLK_DIV = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic run_i,
    output logic sclk_o,
    output logic rise_o,
    output logic last_o
);
    localparam logic [3:0] DIV_LAST = 4'(SCLK_DIV - 1);

    logic [3:0] div_q, div_d;
    logic       sclk_q, sclk_d;
    logic [4:0] falls_q, falls_d;
    logic       tick_s;
    logic       fall_s;

    assign tick_s = run_i && (div_q == DIV_LAST);
    assign fall_s = tick_s && sclk_q;
    assign rise_o = tick_s && !sclk_q;
    assign last_o = (falls_q == 5'd16);
    assign sclk_o = sclk_q;

    // Next-state for the divider, sclk level and falling-edge count.
    always_comb begin
        div_d   = div_q;
        sclk_d  = sclk_q;
        falls_d = falls_q;
        if (!run_i) begin
            div_d   = 4'd0;
            sclk_d  = 1'b1;
            falls_d = 5'd0;
        end else if (tick_s) begin
            div_d  = 4'd0;
            sclk_d = ~sclk_q;
            if (fall_s) begin
                falls_d = falls_q + 5'd1;
            end else begin
                falls_d = falls_q;
            end
        end else begin
            div_d = div_q + 4'd1;
        end
    end

    // Divider state registers; reset parks sclk high.
    always_ff @(posedge clk) begin
        if (reset) begin
            div_q   <= 4'd0;
            sclk_q  <= 1'b1;
            falls_q <= 5'd0;
        end else begin
            div_q   <= div_d;
            sclk_q  <= sclk_d;
            falls_q <= falls_d;
        end
    end

endmodule

// File: rtl/dacxx1s101.sv
// dacxx1s101: write controller for the TI DACxx1S101 serial DAC family.
// Serializes one 16-bit frame (00, PD1:PD0, sample, zero pad) per active-low
// start request and answers with an active-low completion held until the
// request is released. Optional build macro DACXX1S101_SKIP_REDUNDANT_EN
// suppresses frames whose {pdMode, datain} repeats the last word sent.
module dacxx1s101
    import dacxx1s101_pkg::*;
#(
    parameter int DAC_RES          = 12,
    parameter int SCLK_DIV         = 1,
    parameter int SYNC_HIGH_CYCLES = 2
) (
    input  logic             clk,
    input  logic             reset,
    dacxx1s101_if.slave      bus
);
    localparam logic [3:0] QUIET_LOAD = 4'(SYNC_HIGH_CYCLES);

    state_e                state_q, state_d;
    logic [FRAME_BITS-1:0] shift_q, shift_d;
    logic                  sync_q, sync_d;
    logic                  mosi_q, mosi_d;
    logic                  wc_q, wc_d;
    logic                  busy_q, busy_d;
    logic                  armed_q, armed_d;
    logic [3:0]            quiet_q, quiet_d;

    logic                  run_s;
    logic                  sclk_s;
    logic                  rise_s;
    logic                  last_s;
    logic [11:0]           data_s;
    logic [FRAME_BITS-1:0] frame_s;
    logic                  req_s;
    logic                  send_s;
    logic                  skip_s;

    assign run_s   = (state_q == SHIFT);
    assign data_s  = 12'(bus.datain);
    assign frame_s = pack_frame(bus.pdMode, data_s, DAC_RES);
    assign req_s   = (state_q == IDLE) && !bus.startWrite && armed_q && (quiet_q == 4'd0);

`ifdef DACXX1S101_SKIP_REDUNDANT_EN
    logic [DAC_RES+1:0] word_s;
    logic [DAC_RES+1:0] last_word_q, last_word_d;
    logic               last_valid_q, last_valid_d;

    assign word_s = {bus.pdMode, bus.datain};
    assign skip_s = req_s && last_valid_q && (word_s == last_word_q);
    assign send_s = req_s && !skip_s;

    // Remember the word of every frame actually put on the wire.
    always_comb begin
        last_word_d  = last_word_q;
        last_valid_d = last_valid_q;
        if (send_s) begin
            last_word_d  = word_s;
            last_valid_d = 1'b1;
        end else begin
            last_valid_d = last_valid_q;
        end
    end

    // Last-word store; reset forgets it so the first frame always goes out.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_word_q  <= '0;
            last_valid_q <= 1'b0;
        end else begin
            last_word_q  <= last_word_d;
            last_valid_q <= last_valid_d;
        end
    end
`else
    assign skip_s = 1'b0;
    assign send_s = req_s;
`endif

    dacxx1s101_sclk_gen #(
        .SCLK_DIV (SCLK_DIV)
    ) u_sclk_gen (
        .clk    (clk),
        .reset  (reset),
        .run_i  (run_s),
        .sclk_o (sclk_s),
        .rise_o (rise_s),
        .last_o (last_s)
    );

    // FSM next-state, shift register, handshake and quiet-time countdown.
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        sync_d  = sync_q;
        mosi_d  = mosi_q;
        wc_d    = wc_q;
        busy_d  = busy_q;
        armed_d = armed_q;
        quiet_d = quiet_q;

        // Acknowledge release works in every state and re-arms the start.
        if (!wc_q && bus.startWrite) begin
            wc_d    = 1'b1;
            armed_d = 1'b1;
        end else begin
            wc_d    = wc_q;
            armed_d = armed_q;
        end

        case (state_q)
            IDLE: begin
                if (send_s) begin
                    shift_d = frame_s;
                    sync_d  = 1'b0;
                    mosi_d  = frame_s[FRAME_BITS-1];
                    busy_d  = 1'b1;
                    armed_d = 1'b0;
                    state_d = SHIFT;
                end else if (skip_s) begin
                    wc_d    = 1'b0;
                    armed_d = 1'b0;
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                if (rise_s) begin
                    if (last_s) begin
                        sync_d  = 1'b1;
                        wc_d    = 1'b0;
                        quiet_d = QUIET_LOAD;
                        state_d = QUIET;
                    end else begin
                        shift_d = {shift_q[FRAME_BITS-2:0], 1'b0};
                        mosi_d  = shift_q[FRAME_BITS-2];
                    end
                end else begin
                    state_d = SHIFT;
                end
            end
            QUIET: begin
                if (quiet_q == 4'd0) begin
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    quiet_d = quiet_q - 4'd1;
                end
            end
            default: begin
                sync_d  = 1'b1;
                busy_d  = 1'b1;
                quiet_d = QUIET_LOAD;
                state_d = QUIET;
            end
        endcase
    end

    // State and output registers; reset aborts any frame and enforces quiet time.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= QUIET;
            shift_q <= '0;
            sync_q  <= 1'b1;
            mosi_q  <= 1'b0;
            wc_q    <= 1'b1;
            busy_q  <= 1'b1;
            armed_q <= 1'b1;
            quiet_q <= QUIET_LOAD;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            sync_q  <= sync_d;
            mosi_q  <= mosi_d;
            wc_q    <= wc_d;
            busy_q  <= busy_d;
            armed_q <= armed_d;
            quiet_q <= quiet_d;
        end
    end

    assign bus.sync          = sync_q;
    assign bus.sclk          = sclk_s;
    assign bus.mosi          = mosi_q;
    assign bus.writeComplete = wc_q;
    assign bus.busy          = busy_q;

endmodule

// File: tb/tb_dacxx1s101.sv
// tb_dacxx1s101: two controller instances (12-bit / SCLK_DIV=1 / quiet 2 and
// 8-bit / SCLK_DIV=3 / quiet 4) driven with directed and random requests; the
// wire is decoded like a DAC would and compared to an arithmetic frame model.
module tb_dacxx1s101;

    localparam int A_RES = 12;
    localparam int A_DIV = 1;
    localparam int A_SH  = 2;
    localparam int B_RES = 8;
    localparam int B_DIV = 3;
    localparam int B_SH  = 4;

    logic        clk = 1'b0;
    logic        rst_a;
    logic        rst_b;
    int          total = 0;
    int          bad   = 0;
    logic [15:0] last_w [2];

    dacxx1s101_if #(.DAC_RES(A_RES)) ifa ();
    dacxx1s101_if #(.DAC_RES(B_RES)) ifb ();

    dacxx1s101 #(.DAC_RES(A_RES), .SCLK_DIV(A_DIV), .SYNC_HIGH_CYCLES(A_SH)) dut_a (
        .clk   (clk),
        .reset (rst_a),
        .bus   (ifa)
    );

    dacxx1s101 #(.DAC_RES(B_RES), .SCLK_DIV(B_DIV), .SYNC_HIGH_CYCLES(B_SH)) dut_b (
        .clk   (clk),
        .reset (rst_b),
        .bus   (ifb)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic o_sync(input int w);
        return (w == 0) ? ifa.sync : ifb.sync;
    endfunction
    function automatic logic o_sclk(input int w);
        return (w == 0) ? ifa.sclk : ifb.sclk;
    endfunction
    function automatic logic o_mosi(input int w);
        return (w == 0) ? ifa.mosi : ifb.mosi;
    endfunction
    function automatic logic o_wc(input int w);
        return (w == 0) ? ifa.writeComplete : ifb.writeComplete;
    endfunction
    function automatic logic o_busy(input int w);
        return (w == 0) ? ifa.busy : ifb.busy;
    endfunction
    function automatic int p_div(input int w);
        return (w == 0) ? A_DIV : B_DIV;
    endfunction
    function automatic int p_sh(input int w);
        return (w == 0) ? A_SH : B_SH;
    endfunction

    // Reference frame: PD field weighted at 2^12, the sample scaled up so its
    // MSB lands on bit 11, everything else zero.
    function automatic logic [15:0] model_word(input int w, input logic [1:0] pd, input logic [11:0] data);
        int res;
        int v;
        res = (w == 0) ? A_RES : B_RES;
        v = int'(pd) * 4096 + (int'(data) % (1 << res)) * (1 << (12 - res));
        return 16'(v);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int w, input logic [11:0] data, input logic [1:0] pd, input logic s);
        if (w == 0) begin
            ifa.datain = data;
            ifa.pdMode = pd;
            ifa.startWrite = s;
        end else begin
            ifb.datain = data[7:0];
            ifb.pdMode = pd;
            ifb.startWrite = s;
        end
    endtask

    task automatic set_sw(input int w, input logic s);
        if (w == 0) ifa.startWrite = s;
        else        ifb.startWrite = s;
    endtask

    task automatic wait_idle(input int w, output int n);
        n = 0;
        while (o_busy(w) !== 1'b0 && n < 400) begin
            tick();
            n++;
        end
        chk("idle_reached", o_busy(w), 1'b0);
    endtask

    // Request already driven low; decode one frame off the wire.
    task automatic run_frame(input int w, input logic [15:0] exp, input int exp_wait);
        int waitc, lowc, nfall, plen, d;
        logic ps, pm, s, c, m;
        logic [15:0] word;
        bit phase_ok, mosi_ok;
        d = p_div(w);
        waitc = 0;
        while (o_sync(w) !== 1'b0 && waitc < 400) begin
            tick();
            waitc++;
        end
        chk("start_wait", waitc, exp_wait);
        if (o_sync(w) !== 1'b0) return;
        word = 16'h0;
        nfall = 0;
        lowc = 1;
        plen = 1;
        phase_ok = 1'b1;
        mosi_ok = 1'b1;
        ps = o_sclk(w);
        pm = o_mosi(w);
        for (int i = 0; i < 2000; i++) begin
            tick();
            s = o_sync(w);
            c = o_sclk(w);
            m = o_mosi(w);
            if (ps === 1'b1 && c === 1'b0) begin
                word = {word[14:0], pm};
                nfall++;
            end
            if (m !== pm && !(ps === 1'b0 && c === 1'b1)) mosi_ok = 1'b0;
            if (c !== ps) begin
                if (plen != d) phase_ok = 1'b0;
                plen = 1;
            end else begin
                plen++;
            end
            if (s !== 1'b0) break;
            lowc++;
            ps = c;
            pm = m;
        end
        chk("sync_low_cycles", lowc, 32 * d);
        chk("fall_count", nfall, 16);
        chk("frame_word", word, exp);
        chk("sclk_phase_len", phase_ok, 1'b1);
        chk("mosi_stable", mosi_ok, 1'b1);
        chk("wc_at_sync_rise", o_wc(w), 1'b0);
        chk("sclk_at_sync_rise", o_sclk(w), 1'b1);
        last_w[w] = exp;
    endtask

    // Called right after sync rose: release the request after d cycles.
    task automatic ack(input int w, input int d);
        int busy_k;
        busy_k = -1;
        if (d == 0) set_sw(w, 1'b1);
        for (int k = 1; k < 300; k++) begin
            tick();
            if (k == d) chk("ack_hold", o_wc(w), 1'b0);
            if (k == d + 1) chk("ack_release", o_wc(w), 1'b1);
            if (busy_k < 0 && o_busy(w) === 1'b0) busy_k = k;
            if (k == d) set_sw(w, 1'b1);
            if (k > d + 1 && busy_k >= 0) break;
        end
        chk("quiet_len", busy_k, p_sh(w) + 1);
    endtask

    task automatic send(input int w, input logic [11:0] data, input logic [1:0] pd, input int ackd);
        drive(w, data, pd, 1'b0);
        run_frame(w, model_word(w, pd, data), 1);
        ack(w, ackd);
    endtask

    task automatic rand_send(input int w);
        logic [11:0] data;
        logic [1:0]  pd;
        do begin
            data = 12'($urandom);
            pd   = 2'($urandom_range(0, 3));
        end while (model_word(w, pd, data) == last_w[w]);
        send(w, data, pd, int'($urandom_range(0, 3)));
    endtask

    initial begin
        int n, sl, wh, nf;
        logic ps, c;
        last_w[0] = 16'hFFFF;
        last_w[1] = 16'hFFFF;
        rst_a = 1'b1;
        rst_b = 1'b1;
        drive(0, 12'h000, 2'b00, 1'b1);
        drive(1, 12'h000, 2'b00, 1'b1);
        repeat (3) tick();

        chk("rst_sync", o_sync(0), 1'b1);
        chk("rst_sclk", o_sclk(0), 1'b1);
        chk("rst_mosi", o_mosi(0), 1'b0);
        chk("rst_wc", o_wc(0), 1'b1);
        chk("rst_busy", o_busy(0), 1'b1);
        chk("rst_b_sync", o_sync(1), 1'b1);
        chk("rst_b_busy", o_busy(1), 1'b1);

        rst_a = 1'b0;
        rst_b = 1'b0;
        wait_idle(0, n);
        chk("reset_quiet", n, A_SH + 1);
        wait_idle(1, n);

        send(0, 12'hABC, 2'b00, 0);
        send(0, 12'h000, 2'b11, 1);
        for (int i = 0; i < 8; i++) rand_send(0);

        // Request held low through two frame periods: only one frame.
        drive(0, 12'h5A5, 2'b01, 1'b0);
        run_frame(0, model_word(0, 2'b01, 12'h5A5), 1);
        sl = 0;
        wh = 0;
        repeat (100) begin
            tick();
            if (o_sync(0) === 1'b0) sl++;
            if (o_wc(0) !== 1'b0) wh++;
        end
        chk("hold_no_second_frame", sl, 0);
        chk("hold_wc_stays_low", wh, 0);
        set_sw(0, 1'b1);
        tick();
        chk("hold_release_ack", o_wc(0), 1'b1);
        send(0, 12'h3C3, 2'b10, 0);

        // Reset landing on the 7th sclk fall aborts the frame.
        drive(0, 12'h6D2, 2'b00, 1'b0);
        n = 0;
        while (o_sync(0) !== 1'b0 && n < 100) begin
            tick();
            n++;
        end
        nf = 0;
        ps = o_sclk(0);
        for (int i = 0; i < 200 && nf < 6; i++) begin
            tick();
            c = o_sclk(0);
            if (ps === 1'b1 && c === 1'b0) nf++;
            ps = c;
        end
        chk("abort_falls_seen", nf, 6);
        repeat (2 * A_DIV - 1) tick();
        rst_a = 1'b1;
        drive(0, 12'h777, 2'b01, 1'b0);
        tick();
        chk("abort_sync", o_sync(0), 1'b1);
        chk("abort_sclk", o_sclk(0), 1'b1);
        chk("abort_wc", o_wc(0), 1'b1);
        chk("abort_busy", o_busy(0), 1'b1);
        chk("abort_mosi", o_mosi(0), 1'b0);
        rst_a = 1'b0;
        run_frame(0, model_word(0, 2'b01, 12'h777), A_SH + 2);
        ack(0, 0);

        // 8-bit, slow-SCLK instance.
        send(1, 12'h0FF, 2'b00, 0);
        send(1, 12'h05A, 2'b10, 2);
        rand_send(1);
        rand_send(1);

        // Repeated word.
        send(0, 12'h123, 2'b00, 0);
`ifdef DACXX1S101_SKIP_REDUNDANT_EN
        drive(0, 12'h123, 2'b00, 1'b0);
        tick();
        chk("skip_wc", o_wc(0), 1'b0);
        chk("skip_sync", o_sync(0), 1'b1);
        chk("skip_busy", o_busy(0), 1'b0);
        set_sw(0, 1'b1);
        tick();
        chk("skip_ack", o_wc(0), 1'b1);
        chk("skip_sync_after", o_sync(0), 1'b1);
`else
        send(0, 12'h123, 2'b00, 0);
`endif
        send(0, 12'h124, 2'b00, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
